// File: rtl/shift_feeder_if.sv
// Load-side handshake for the serial shift feeder.
// The master offers a word; the feeder (slave) reports when it can accept.
interface shift_feeder_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             load_dir;

    modport master (
        output load_valid,
        output load_data,
        output load_dir,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dir,
        output load_ready
    );
endinterface

// File: rtl/shift_feeder.sv
// Serialises a parallel word into sl/sr/din strobes for a downstream
// left/right shift register, one bit per strobe, with stall support.
module shift_feeder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    shift_feeder_if.slave  ld,
    input  logic           hold,
    output logic           sl,
    output logic           sr,
    output logic           din,
    output logic           busy,
    output logic           done
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] word;
    logic             dir;
    logic [IW-1:0]    idx;

    // MSB first when shifting left, LSB first when shifting right,
    // so the downstream register ends up holding the word unchanged.
    always_comb begin
        idx = '0;
        if (dir)
            idx = cnt[IW-1:0];
        else
            idx = IW'(WIDTH - 1) - cnt[IW-1:0];
    end

    assign ld.load_ready = (state == IDLE) && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
            dir   <= 1'b0;
            sl    <= 1'b0;
            sr    <= 1'b0;
            din   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    sl   <= 1'b0;
                    sr   <= 1'b0;
                    done <= 1'b0;
                    if (ld.load_valid) begin
                        word  <= ld.load_data;
                        dir   <= ld.load_dir;
                        state <= SHIFT;
                        busy  <= 1'b1;
                        if (!hold) begin
                            sl  <= ~ld.load_dir;
                            sr  <= ld.load_dir;
                            din <= ld.load_dir ? ld.load_data[0]
                                               : ld.load_data[WIDTH-1];
                            cnt <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_W'(WIDTH)) begin
                        sl    <= 1'b0;
                        sr    <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (hold) begin
                        sl <= 1'b0;
                        sr <= 1'b0;
                    end else begin
                        sl  <= ~dir;
                        sr  <= dir;
                        din <= word[idx];
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    sl    <= 1'b0;
                    sr    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_feeder.sv
// Directed plus randomised checks of shift_feeder against a model of the
// downstream shift register and the transfer timing rules.
module tb_shift_feeder;
    logic clk;
    logic reset;
    logic hold;
    logic sl, sr, din, busy, done;

    int checks;
    int errors;
    int cyc;
    int acc_cyc;
    int p0;
    int nstb;
    logic [7:0] q;

    shift_feeder_if #(.WIDTH(8)) ld ();

    shift_feeder #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ld    (ld),
        .hold  (hold),
        .sl    (sl),
        .sr    (sr),
        .din   (din),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp,
                         input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives the word for the next posedge and follows
    // the transfer until the first IDLE cycle after done.
    task automatic xfer(input logic [7:0] w, input logic d,
                        input logic [31:0] hv, input int junk,
                        input bit keep_valid);
        int issued;
        int exp_done;
        int n;
        bit got_done;
        issued   = 0;
        exp_done = -1;
        for (int k = 0; k < 32; k++) begin
            if (issued == 8) begin
                exp_done = k + 1;
                break;
            end
            if (!hv[k]) issued++;
        end
        check(32'(ld.load_ready), 1, "ready_at_accept");
        acc_cyc       = cyc;
        ld.load_valid = 1'b1;
        ld.load_data  = w;
        ld.load_dir   = d;
        hold          = hv[0];
        n        = 0;
        got_done = 1'b0;
        for (int k = 1; k <= 40 && !got_done; k++) begin
            @(negedge clk);
            ld.load_valid = keep_valid || (k == junk);
            if (k == junk) begin
                ld.load_data = 8'hFF;
                ld.load_dir  = ~d;
            end
            hold = (k < 32) ? hv[k] : 1'b0;
            check(32'(sl & sr), 0, "sl_sr_excl");
            if (sl | sr) begin
                check({30'd0, sl, sr}, d ? 32'd1 : 32'd2, "strobe_dir");
                check(32'(din), 32'(d ? w[n] : w[7-n]), "din_bit");
                q = sl ? {q[6:0], din} : {din, q[7:1]};
                n++;
            end
            if (done) begin
                got_done = 1'b1;
                check(k, exp_done, "done_cycle");
                check(n, 8, "strobe_count");
                check(32'(busy), 1, "busy_in_done");
                check({24'd0, q}, {24'd0, w}, "model_q");
            end else begin
                check(32'(ld.load_ready), 0, "ready_low_busy");
            end
        end
        check(32'(got_done), 1, "done_seen");
        @(negedge clk);
        hold = 1'b0;
        check(32'(ld.load_ready), 1, "ready_after_done");
        check(32'(busy), 0, "busy_idle");
        check(32'(done), 0, "done_pulse_one");
    endtask

    initial begin
        logic [7:0]  w;
        logic        d;
        logic [31:0] hv;
        checks        = 0;
        errors        = 0;
        q             = 8'h00;
        reset         = 1'b0;
        hold          = 1'b0;
        ld.load_valid = 1'b0;
        ld.load_data  = 8'h00;
        ld.load_dir   = 1'b0;
        #1;
        check({26'd0, sl, sr, din, done, busy, ld.load_ready}, 0, "reset_outs");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check(32'(ld.load_ready), 1, "ready_post_reset");

        xfer(8'hA5, 1'b0, 32'h0, 0, 1'b0);
        xfer(8'h3C, 1'b1, 32'h0, 0, 1'b0);
        @(negedge clk);
        xfer(8'hF0, 1'b0, 32'h0000_000C, 0, 1'b0);
        xfer(8'h55, 1'b0, 32'h0, 4, 1'b0);

        // Abort after five strobes; outputs must clear without a clock edge.
        ld.load_valid = 1'b1;
        ld.load_data  = 8'h5A;
        ld.load_dir   = 1'b0;
        nstb          = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ld.load_valid = 1'b0;
            nstb += int'(sl);
        end
        check(nstb, 5, "pre_abort_strobes");
        #2;
        reset = 1'b0;
        #1;
        check({26'd0, sl, sr, din, done, busy, ld.load_ready}, 0, "abort_outs");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check(32'(ld.load_ready), 1, "ready_post_abort");
        xfer(8'h81, 1'b1, 32'h0, 0, 1'b0);

        xfer(8'h12, 1'b0, 32'h0, 0, 1'b1);
        p0 = acc_cyc;
        xfer(8'h34, 1'b1, 32'h0, 0, 1'b0);
        check(acc_cyc - p0, 10, "b2b_period");

        for (int r = 0; r < 8; r++) begin
            w  = 8'($urandom);
            d  = 1'($urandom_range(0, 1));
            hv = $urandom & $urandom & 32'h0000_FFFF;
            xfer(w, d, hv, int'($urandom_range(0, 6)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_feeder.md
Name: shift_feeder

Overview:
- Upstream feeder for the 8-bit left/right shift register stage.
- Accepts a parallel word with a valid/ready handshake and a direction bit.
- Drives the downstream sl/sr/din serially, one bit per strobe, so the downstream register holds exactly the loaded word after WIDTH strobes.
- Supports stall (hold) and signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, word length and number of shift strobes per transfer (legal range >= 2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset; low clears all state immediately.
- load_valid  in  1  load_data and load_dir are valid this cycle.
- load_ready  out  1  feeder can accept a word; equals (state==IDLE) and reset high.
- load_data  in  WIDTH  word to serialise.
- load_dir  in  1  0 = shift left (drive sl), 1 = shift right (drive sr).
- hold  in  1  stall request; suppresses the next strobe while high.
- sl  out  1  shift-left strobe to downstream; registered.
- sr  out  1  shift-right strobe to downstream; registered.
- din  out  1  serial bit to downstream; registered; valid whenever sl or sr is 1.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse after the last strobe.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, cnt=0, shadow word=0, dir=0.
  - sl=sr=din=0, busy=0, done=0, load_ready=0 while reset is low.
- States: IDLE, SHIFT, DONE. All outputs except load_ready are registered.
- IDLE:
  - load_ready=1.
  - On a posedge with load_valid=1: capture load_data into the shadow word and load_dir into dir; go to SHIFT.
  - On that same edge: if hold=0, issue the first strobe and set cnt=1; if hold=1, no strobe and cnt=0.
- Bit order, chosen so the downstream register equals load_data after WIDTH strobes:
  - dir=0: MSB first, din = word[WIDTH-1-cnt].
  - dir=1: LSB first, din = word[cnt].
- SHIFT, at each posedge:
  - cnt==WIDTH: sl=sr=0, done=1, go to DONE.
  - else if hold=1: sl=sr=0, din unchanged, cnt unchanged.
  - else: strobe (sl=~dir, sr=dir), din = next bit, cnt=cnt+1.
- DONE: exactly one cycle with done=1, busy=1; then IDLE with done=0.
- Latency with no hold: strobes occupy cycles 1..WIDTH after the accept edge; done occurs in cycle WIDTH+1; load_ready=1 in cycle WIDTH+2. Each hold cycle extends this by one.
- Invariants:
  - sl&sr==0 always.
  - Exactly WIDTH strobes per accepted word.
  - The strobe count ignores hold duration.
- load_valid while busy: ignored, no capture. Data changes on load_data after accept have no effect.
- Back-to-back: a new word can be accepted on the first IDLE edge after DONE; minimum period is WIDTH+2 cycles.
- Reset mid-transfer: the transfer is aborted immediately and outputs clear asynchronously. No done pulse. After release, the block is in IDLE and awaits a fresh load.
- Simultaneous hold and accept: the word is captured, the first strobe is deferred, and cnt=0.

Test Plan:
- Reset release, then load 0xA5 with dir=0 and hold=0 -> sl high 8 consecutive cycles; din=1,0,1,0,0,1,0,1; done 1 cycle later; reference shift-register model Q=0xA5.
- Load 0x3C with dir=1 -> sr high 8 cycles; din=0,0,1,1,1,1,0,0; sl stays 0; model Q=0x3C; load_ready low for 9 cycles after accept.
- Load 0xF0 with dir=0, hold=1 asserted on the 3rd and 4th strobe edges -> 2 gap cycles with sl=0; still exactly 8 strobes; done in cycle 11; model Q=0xF0.
- During a 0x55 transfer, pulse load_valid with 0xFF on cycle 4 -> ignored; model Q=0x55; next accept occurs only once load_ready is high.
- Assert reset low mid-transfer after 5 strobes (no clock edge needed) -> sl=sr=din=done=busy=0 immediately; after release, load 0x81 with dir=1 -> correct 8-strobe transfer.
- Back-to-back loads 0x12 (left) then 0x34 (right) with load_valid held high -> second accept on the first IDLE edge; min gap WIDTH+2; model Q=0x12 then 0x34.
